flash_sched: RTL and testbench

FLASH_SCHED -- requirements
Module: flash_sched

---
 rtl/flash_pkg.sv | 13 +
 rtl/blink_chan.sv | 109 ++++++++++
 rtl/flash_sched.sv | 50 +++++
 tb/tb_flash_sched.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_pkg.sv
// Shared definitions for the flash scheduler: channel state encoding and default sizes.
package flash_pkg;

  localparam int unsigned NCH_DEF = 4;
  localparam int unsigned CW_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } chan_state_e;

endpackage

// File: rtl/blink_chan.sv
// One blink channel: IDLE/ON/OFF sequencer with a tick-driven down-counter.
module blink_chan
  import flash_pkg::*;
#(
  parameter int unsigned CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          sync,
  input  logic          wr,
  input  logic          en,
  input  logic [CW-1:0] on,
  input  logic [CW-1:0] off,
  output logic          blink,
  output logic          phase_start
);

  chan_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] on_q, on_d;
  logic [CW-1:0] off_q, off_d;
  logic          en_q, en_d;
  logic          blink_d;
  logic          phase_start_d;
  logic          en_eff;

  // Zero on and zero off durations can never blink, so they disable the channel.
  assign en_eff = en && ((on != '0) || (off != '0));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      on_q        <= '0;
      off_q       <= '0;
      en_q        <= 1'b0;
      blink       <= 1'b0;
      phase_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      on_q        <= on_d;
      off_q       <= off_d;
      en_q        <= en_d;
      blink       <= blink_d;
      phase_start <= phase_start_d;
    end
  end

  // Priority: configuration write, then sync restart, then tick.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    on_d          = on_q;
    off_d         = off_q;
    en_d          = en_q;
    phase_start_d = 1'b0;

    if (wr) begin
      on_d  = on;
      off_d = off;
      en_d  = en_eff;
      if (!en_eff) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else if (on != '0) begin
        state_d       = ON;
        cnt_d         = on;
        phase_start_d = 1'b1;
      end else begin
        state_d = OFF;
        cnt_d   = off;
      end
    end else if (sync && en_q) begin
      if (on_q != '0) begin
        state_d       = ON;
        cnt_d         = on_q;
        phase_start_d = 1'b1;
      end else begin
        state_d = OFF;
        cnt_d   = off_q;
      end
    end else if (tick && (state_q != IDLE)) begin
      if (cnt_q > CW'(1)) begin
        cnt_d = cnt_q - CW'(1);
      end else if (state_q == ON) begin
        // A zero-length OFF phase keeps the channel parked in ON.
        if (off_q != '0) begin
          state_d = OFF;
          cnt_d   = off_q;
        end else begin
          cnt_d = on_q;
        end
      end else begin
        if (on_q != '0) begin
          state_d       = ON;
          cnt_d         = on_q;
          phase_start_d = 1'b1;
        end else begin
          cnt_d = off_q;
        end
      end
    end

    blink_d = (state_d == ON);
  end

endmodule

// File: rtl/flash_sched.sv
// Multi-channel flash scheduler: decodes config writes and fans tick/sync out to channels.
module flash_sched
  import flash_pkg::*;
#(
  parameter int unsigned NCH = NCH_DEF,
  parameter int unsigned CW  = CW_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    sync,
  input  logic                    cfg_wr,
  input  logic [$clog2(NCH)-1:0]  cfg_ch,
  input  logic                    cfg_en,
  input  logic [CW-1:0]           cfg_on,
  input  logic [CW-1:0]           cfg_off,
  output logic                    cfg_ack,
  output logic [NCH-1:0]          blink,
  output logic [NCH-1:0]          phase_start
);

  localparam int unsigned CHW = $clog2(NCH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_ack <= 1'b0;
    end else begin
      cfg_ack <= cfg_wr;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    logic wr_c;
    assign wr_c = cfg_wr && (cfg_ch == CHW'(i));

    blink_chan #(.CW(CW)) u_chan (
      .clk         (clk),
      .reset       (reset),
      .tick        (tick),
      .sync        (sync),
      .wr          (wr_c),
      .en          (cfg_en),
      .on          (cfg_on),
      .off         (cfg_off),
      .blink       (blink[i]),
      .phase_start (phase_start[i])
    );
  end

endmodule

// File: tb/tb_flash_sched.sv
// Self-checking bench for flash_sched against a phase/ticks-left reference model.
module tb_flash_sched;

  localparam int NCH = 4;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          tick, sync, cfg_wr, cfg_en;
  logic [1:0]    cfg_ch;
  logic [CW-1:0] cfg_on, cfg_off;
  logic          cfg_ack;
  logic [NCH-1:0] blink, phase_start;

  int passed = 0;
  int total  = 0;

  // Reference model: per channel, stored config, current phase (0 idle, 1 lit, 2 dark)
  // and number of ticks still to elapse in the current phase.
  int m_en[NCH], m_on[NCH], m_off[NCH], m_ph[NCH], m_left[NCH];
  logic [NCH-1:0] exp_blink, exp_ps;
  logic           exp_ack;

  flash_sched #(.NCH(NCH), .CW(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .sync        (sync),
    .cfg_wr      (cfg_wr),
    .cfg_ch      (cfg_ch),
    .cfg_en      (cfg_en),
    .cfg_on      (cfg_on),
    .cfg_off     (cfg_off),
    .cfg_ack     (cfg_ack),
    .blink       (blink),
    .phase_start (phase_start)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < NCH; i++) begin
      m_en[i] = 0; m_on[i] = 0; m_off[i] = 0; m_ph[i] = 0; m_left[i] = 0;
    end
    exp_blink = '0; exp_ps = '0; exp_ack = 1'b0;
  endtask

  // Enter the lit phase if it has length, otherwise the dark one.
  task automatic model_restart(input int i);
    if (m_on[i] > 0) begin m_ph[i] = 1; m_left[i] = m_on[i]; exp_ps[i] = 1'b1; end
    else begin m_ph[i] = 2; m_left[i] = m_off[i]; end
  endtask

  task automatic model_step(input logic t, input logic s, input logic w, input int ch,
                            input logic e, input int on_v, input int off_v);
    exp_ack = w;
    exp_ps  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w && ch == i) begin
        m_on[i] = on_v; m_off[i] = off_v;
        m_en[i] = (e && (on_v + off_v) > 0) ? 1 : 0;
        if (m_en[i] == 0) m_ph[i] = 0;
        else model_restart(i);
      end else if (s && m_en[i] == 1) begin
        model_restart(i);
      end else if (t && m_ph[i] != 0) begin
        m_left[i]--;
        if (m_left[i] == 0) begin
          if (m_ph[i] == 1) begin
            if (m_off[i] > 0) begin m_ph[i] = 2; m_left[i] = m_off[i]; end
            else m_left[i] = m_on[i];
          end else begin
            if (m_on[i] > 0) begin m_ph[i] = 1; m_left[i] = m_on[i]; exp_ps[i] = 1'b1; end
            else m_left[i] = m_off[i];
          end
        end
      end
      exp_blink[i] = (m_ph[i] == 1);
    end
  endtask

  // Drive one cycle of inputs (just after a rising edge) and advance the model with it.
  task automatic cycle(input logic t, input logic s, input logic w, input int ch,
                       input logic e, input int on_v, input int off_v);
    tick = t; sync = s; cfg_wr = w; cfg_ch = 2'(ch); cfg_en = e;
    cfg_on = CW'(on_v); cfg_off = CW'(off_v);
    model_step(t, s, w, ch, e, on_v, off_v);
    @(posedge clk);
    #1;
    tick = 1'b0; sync = 1'b0; cfg_wr = 1'b0;
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0);
  endtask

  task automatic tick_cycle();
    cycle(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 0);
  endtask

  task automatic write_cycle(input int ch, input logic e, input int on_v, input int off_v);
    cycle(1'b0, 1'b0, 1'b1, ch, e, on_v, off_v);
  endtask

  task automatic apply_reset();
    #2 reset = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick = 0; sync = 0; cfg_wr = 0; cfg_ch = '0; cfg_en = 0; cfg_on = '0; cfg_off = '0;
    reset = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({cfg_ack, phase_start, blink} !== 9'b0) $display("FAIL reset_state: got %b want 0", {cfg_ack, phase_start, blink});
    else passed++;
    // Release away from the edge; the very next edge must accept a write.
    #3 reset = 1'b1;
    #1;
    write_cycle(1, 1'b1, 3, 2);
    total++;
    if (cfg_ack !== 1'b1 || blink !== 4'b0010 || phase_start !== 4'b0010)
      $display("FAIL first_write: ack=%b blink=%b ps=%b want 1 0010 0010", cfg_ack, blink, phase_start);
    else passed++;
  endtask

  task automatic test_basic();
    int ps_after5;
    apply_reset();
    write_cycle(0, 1'b1, 2, 3);
    total++;
    if (blink[0] !== 1'b1 || phase_start[0] !== 1'b1)
      $display("FAIL basic_enable: blink=%b ps=%b want 1 1", blink[0], phase_start[0]);
    else passed++;
    ps_after5 = 0;
    for (int k = 1; k <= 10; k++) begin
      tick_cycle();
      if (k == 5) ps_after5 = phase_start[0];
      repeat (3) begin
        total++;
        if (blink !== exp_blink || phase_start !== exp_ps)
          $display("FAIL basic_tick%0d: blink=%b ps=%b want %b %b", k, blink, phase_start, exp_blink, exp_ps);
        else passed++;
        idle_cycle();
      end
    end
    total++;
    if (ps_after5 !== 1) $display("FAIL basic_ps_5th: got %0d want 1", ps_after5);
    else passed++;
  endtask

  task automatic test_hold();
    int bad_ps;
    apply_reset();
    write_cycle(1, 1'b1, 0, 5);
    write_cycle(2, 1'b1, 5, 0);
    bad_ps = 0;
    total++;
    if (blink[2:1] !== 2'b10 || phase_start[2] !== 1'b1)
      $display("FAIL hold_enable: blink=%b ps=%b want x10x with ps[2]=1", blink, phase_start);
    else passed++;
    for (int k = 0; k < 30; k++) begin
      tick_cycle();
      total++;
      if (blink[2:1] !== 2'b10) $display("FAIL hold_level%0d: blink=%b want 10", k, blink[2:1]);
      else passed++;
      if (phase_start[2:1] !== 2'b00) bad_ps++;
    end
    total++;
    if (bad_ps !== 0) $display("FAIL hold_no_ps: got %0d pulses want 0", bad_ps);
    else passed++;
  endtask

  task automatic test_sync();
    apply_reset();
    write_cycle(0, 1'b1, 1, 1);
    write_cycle(1, 1'b1, 1, 1);
    tick_cycle();
    total++;
    if (blink[1:0] !== 2'b00) $display("FAIL sync_pre: blink=%b want 00", blink[1:0]);
    else passed++;
    cycle(1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 0);
    total++;
    if (phase_start !== 4'b0011 || blink !== 4'b0011)
      $display("FAIL sync_restart: ps=%b blink=%b want 0011 0011", phase_start, blink);
    else passed++;
    // Sync coincident with a write: written channel follows the write.
    cycle(1'b0, 1'b1, 1'b1, 1, 1'b0, 0, 0);
    total++;
    if (blink !== 4'b0001 || phase_start !== 4'b0001)
      $display("FAIL sync_vs_write: blink=%b ps=%b want 0001 0001", blink, phase_start);
    else passed++;
  endtask

  task automatic test_write_tick();
    apply_reset();
    write_cycle(0, 1'b1, 2, 2);
    write_cycle(3, 1'b1, 2, 2);
    tick_cycle();
    cycle(1'b1, 1'b0, 1'b1, 3, 1'b1, 3, 1);
    total++;
    if (blink !== 4'b1000 || phase_start !== 4'b1000)
      $display("FAIL write_tick: blink=%b ps=%b want 1000 1000", blink, phase_start);
    else passed++;
    // New ch3 config has on=3, so two more ticks keep it lit.
    tick_cycle();
    tick_cycle();
    total++;
    if (blink !== exp_blink || blink[3] !== 1'b1)
      $display("FAIL write_tick_reload: blink=%b want %b", blink, exp_blink);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int lit;
    apply_reset();
    write_cycle(0, 1'b1, 4, 2);
    #2 reset = 1'b0;
    #1;
    total++;
    if (blink[0] !== 1'b0 || cfg_ack !== 1'b0) $display("FAIL async_reset: blink=%b ack=%b want 0 0", blink[0], cfg_ack);
    else passed++;
    model_clear();
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    lit = 0;
    for (int k = 0; k < 10; k++) begin
      tick_cycle();
      if (blink !== 4'b0 || phase_start !== 4'b0) lit++;
    end
    total++;
    if (lit !== 0) $display("FAIL reset_stays_idle: %0d active cycles want 0", lit);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] acks;
    apply_reset();
    acks = '0;
    tick = 0; sync = 0; cfg_en = 1'b1; cfg_on = 4'd2; cfg_off = 4'd2;
    for (int k = 0; k < 3; k++) begin
      cfg_wr = 1'b1; cfg_ch = 2'(k);
      @(posedge clk);
      #1;
      acks[k] = cfg_ack;
    end
    cfg_wr = 1'b0;
    @(posedge clk);
    #1;
    acks[3] = cfg_ack;
    total++;
    if (acks !== 4'b0111) $display("FAIL b2b_ack: got %b want 0111", acks);
    else passed++;
    total++;
    if (blink !== 4'b0111) $display("FAIL b2b_blink: got %b want 0111", blink);
    else passed++;
    model_clear();
  endtask

  task automatic test_random();
    int errs;
    logic t, s, w, e;
    int ch, onv, offv;
    apply_reset();
    errs = 0;
    for (int k = 0; k < 1500; k++) begin
      t = ($urandom_range(0, 1) == 1);
      s = ($urandom_range(0, 15) == 0);
      w = ($urandom_range(0, 7) == 0);
      e = ($urandom_range(0, 4) != 0);
      ch = $urandom_range(0, NCH - 1);
      onv = $urandom_range(0, 3);
      offv = $urandom_range(0, 3);
      cycle(t, s, w, ch, e, onv, offv);
      total++;
      if ({cfg_ack, phase_start, blink} !== {exp_ack, exp_ps, exp_blink}) begin
        errs++;
        if (errs <= 5)
          $display("FAIL random_c%0d: ack/ps/blink=%b want %b", k, {cfg_ack, phase_start, blink},
                   {exp_ack, exp_ps, exp_blink});
      end else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_sync();
    test_write_tick();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
